// File: rtl/delay_chain_probe.sv
// delay_chain_probe: drives the head of the on-chip register delay chain and
// watches its tail. A measurement flushes the chain, fires a one-cycle pulse,
// then reports the cycles until the pulse arrives and how long it stays high.
//
// Handshake: start is a level request that is only looked at in IDLE; busy is
// high from the cycle after start is accepted until DONE. done pulses for one
// cycle, with busy already low, when latency/width/timeout/stuck are valid.
// A start seen while busy or in DONE is dropped, not queued.
module delay_chain_probe #(
  parameter int LW      = 10,
  parameter int MAX_LAT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          chain_out,
  output logic          launch,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          stuck,
  output logic [LW-1:0] latency,
  output logic [LW-1:0] width,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_FIRE  = 3'd2,
    S_RISE  = 3'd3,
    S_HIGH  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [LW-1:0] CNT_MAX    = LW'(MAX_LAT);
  localparam logic [LW-1:0] FLUSH_LAST = LW'(MAX_LAT - 1);
  localparam logic [LW-1:0] CNT_ONE    = LW'(1);

  state_t        state;
  logic [LW-1:0] cnt;

  assign dbg_state = state;

  // Measurement FSM; every output is a register so the chain head is glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      launch  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      stuck   <= 1'b0;
      latency <= '0;
      width   <= '0;
    end else begin
      done   <= 1'b0;
      launch <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FLUSH;
            busy    <= 1'b1;
            timeout <= 1'b0;
            stuck   <= 1'b0;
            cnt     <= '0;
          end
        end
        S_FLUSH: begin
          // Hold the head low long enough for any stale pulse to drain out.
          if (cnt == FLUSH_LAST) begin
            cnt <= '0;
            if (chain_out) begin
              stuck <= 1'b1;
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= S_FIRE;
              launch <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_FIRE: begin
          // launch is high during this cycle; cnt is 0 so a direct loopback reads 0.
          cnt <= CNT_ONE;
          if (chain_out) begin
            latency <= cnt;
            state   <= S_HIGH;
          end else begin
            state <= S_RISE;
          end
        end
        S_RISE: begin
          if (chain_out) begin
            latency <= cnt;
            cnt     <= CNT_ONE;
            state   <= S_HIGH;
          end else if (cnt == CNT_MAX) begin
            timeout <= 1'b1;
            latency <= CNT_MAX;
            width   <= '0;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          // The arrival cycle already counted as the first high cycle.
          if (!chain_out) begin
            width <= cnt;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            timeout <= 1'b1;
            width   <= CNT_MAX;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_chain_probe.sv
// Bench for delay_chain_probe: a model delay chain (shift register with a
// selectable tap) sits between launch and chain_out, and directed runs check
// latency, width and the sticky flags against hand-computed values.
module tb_delay_chain_probe;

  localparam int LW      = 10;
  localparam int MAX_LAT = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          chain_out;
  logic          launch, busy, done, timeout, stuck;
  logic [LW-1:0] latency, width;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // chain model controls
  int mode = 0;   // 0 tied 0, 1 tied 1, 2 loopback, 3 tap, 4 stretched tap
  int tap  = 0;
  logic [479:0] sr = '0;

  int n_launch;
  int n_done;

  delay_chain_probe #(.LW(LW), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chain_out(chain_out),
    .launch(launch), .busy(busy), .done(done), .timeout(timeout),
    .stuck(stuck), .latency(latency), .width(width), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // register delay chain driven by launch
  always @(posedge clk) sr <= {sr[478:0], launch};

  // tail selection
  always_comb begin
    chain_out = 1'b0;
    case (mode)
      1: chain_out = 1'b1;
      2: chain_out = launch;
      3: chain_out = sr[tap];
      4: chain_out = sr[tap] | sr[tap+1] | sr[tap+2];
      default: chain_out = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for done (bounded), counting launch/done pulses; optionally pokes
  // start for one cycle at cycle 'poke' to show it is ignored while busy.
  task automatic wait_done(input int poke);
    bit seen = 0;
    n_launch = 0;
    n_done   = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (poke >= 0 && i == poke) start = 1'b1;
      if (poke >= 0 && i == poke + 1) start = 1'b0;
      if (launch) n_launch++;
      if (done) begin
        n_done++;
        seen = 1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run(input int m, input int t, input int poke);
    mode = m;
    tap  = t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(poke);
  endtask

  task automatic check_result(input string tag, input int lat, input int wid,
                              input int to, input int st, input int nl);
    check({tag, "_latency"}, 32'(latency), 32'(lat));
    check({tag, "_width"},   32'(width),   32'(wid));
    check({tag, "_timeout"}, 32'(timeout), 32'(to));
    check({tag, "_stuck"},   32'(stuck),   32'(st));
    check({tag, "_launches"}, 32'(n_launch), 32'(nl));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_launch"},  32'(launch),    32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_done"},    32'(done),      32'd0);
    check({tag, "_timeout"}, 32'(timeout),   32'd0);
    check({tag, "_stuck"},   32'(stuck),     32'd0);
    check({tag, "_latency"}, 32'(latency),   32'd0);
    check({tag, "_width"},   32'(width),     32'd0);
    check({tag, "_state"},   32'(dbg_state), 32'd0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: 480-flop chain, start poked mid-run must be ignored
    run(3, 479, 500);
    check_result("n480", 480, 1, 0, 0, 1);
    @(negedge clk);
    check("n480_idle", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("n480_no_queue_state", 32'(dbg_state), 32'd0);
    check("n480_no_queue_busy", 32'(busy), 32'd0);

    // 2: combinational loopback and single flop
    run(2, 0, -1);
    check_result("loop", 0, 1, 0, 0, 1);
    run(3, 0, -1);
    check_result("n1", 1, 1, 0, 0, 1);

    // 3: tail stuck low -> timeout
    run(0, 0, -1);
    check_result("tied0", 1000, 0, 1, 0, 1);

    // 4: tail stuck high -> stuck, no launch; then stretched pulse
    run(1, 0, -1);
    check("tied1_stuck", 32'(stuck), 32'd1);
    check("tied1_timeout", 32'(timeout), 32'd0);
    check("tied1_launches", 32'(n_launch), 32'd0);
    run(4, 9, -1);
    check_result("stretch", 10, 3, 0, 0, 1);

    // 5: start held high -> one measurement, next only after IDLE
    mode = 3;
    tap  = 479;
    @(negedge clk);
    start = 1'b1;
    wait_done(-1);
    check_result("held1", 480, 1, 0, 0, 1);
    check("held1_dones", 32'(n_done), 32'd1);
    @(negedge clk);
    check("held_idle_state", 32'(dbg_state), 32'd0);
    check("held_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_restart_state", 32'(dbg_state), 32'd1);
    check("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(-1);
    check_result("held2", 480, 1, 0, 0, 1);

    // 6: reset during RISE aborts, fresh run measures correctly
    mode = 3;
    tap  = 479;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit in_rise = 0;
      for (int i = 0; i < 2000 && !in_rise; i++) begin
        @(negedge clk);
        if (dbg_state == 3'd3) in_rise = 1;
      end
      check("rst_reach_rise", 32'(in_rise), 32'd1);
    end
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    run(3, 479, -1);
    check_result("after_rst", 480, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
